// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and helpers for the MIPS program-counter fetch unit.
package mips_pc_pkg;

  typedef enum logic [1:0] {
    PCSRC_SEQ    = 2'd0,
    PCSRC_BRANCH = 2'd1,
    PCSRC_JUMP   = 2'd2,
    PCSRC_JR     = 2'd3
  } pc_src_e;

  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC    = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC    = 32'h8000_0008;
  localparam int unsigned KERNEL_BIT = 31;

  // Trap entry always lands in kernel space on a word boundary.
  function automatic logic [31:0] trap_addr(input logic [31:0] vec);
    return {1'b1, vec[30:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control/status bundle between the core and the PC fetch unit.
interface pc_fetch_unit_if;
  import mips_pc_pkg::*;

  logic        stall;
  pc_src_e     pc_src;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic        irq;
  logic        exc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        kernel;
  logic [31:0] epc;
  logic        irq_ack;
  logic        exc_ack;
  logic [31:0] instret;

  modport master (
    output stall, pc_src, branch_taken, imm16, jump_index, jr_target, irq, exc,
    input  pc, pc_plus4, kernel, epc, irq_ack, exc_ack, instret
  );

  modport slave (
    input  stall, pc_src, branch_taken, imm16, jump_index, jr_target, irq, exc,
    output pc, pc_plus4, kernel, epc, irq_ack, exc_ack, instret
  );

endinterface

// File: rtl/pc_fetch_unit_target_calc.sv
// Combinational next-PC candidate for the non-trap paths (branch, jump, JR, sequential).
module pc_target_calc
  import mips_pc_pkg::*;
(
  input  logic        kernel_i,
  input  logic [31:0] pc_plus4_i,
  input  pc_src_e     pc_src_i,
  input  logic        branch_taken_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] jump_index_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] target_o
);

  logic [31:0] br_off;
  logic [31:0] br_sum;
  logic [31:0] target;

  assign br_off = {{14{imm16_i[15]}}, imm16_i, 2'b00};
  assign br_sum = pc_plus4_i + br_off;

  // Branch/jump keep the current mode bit; only a kernel JR may clear it.
  always_comb begin
    target = pc_plus4_i;
    unique case (pc_src_i)
      PCSRC_SEQ:    target = pc_plus4_i;
      PCSRC_BRANCH: if (branch_taken_i)
                      target = (br_sum & 32'h7FFF_FFFF) | {kernel_i, 31'd0};
      PCSRC_JUMP:   target = {kernel_i, pc_plus4_i[30:28], jump_index_i, 2'b00};
      PCSRC_JR:     target = jr_target_i & {kernel_i, {31{1'b1}}};
    endcase
    target_o = target & ~32'h3;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, trap/priority selection, EPC and retired-instruction counter.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = mips_pc_pkg::RESET_PC,
  parameter logic [31:0] IRQ_VEC  = mips_pc_pkg::IRQ_VEC,
  parameter logic [31:0] EXC_VEC  = mips_pc_pkg::EXC_VEC
) (
  input logic            clk,
  input logic            reset,
  pc_fetch_unit_if.slave bus
);
  import mips_pc_pkg::*;

  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] instret_q, instret_d;
  logic        irq_ack_q, irq_ack_d;
  logic        exc_ack_q, exc_ack_d;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        kernel;
  logic        take_irq;
  logic        retire;

  assign pc_plus4 = pc_q + 32'd4;
  assign kernel   = pc_q[KERNEL_BIT];
  // Interrupts are masked in kernel mode and lose to a simultaneous exception.
  assign take_irq = bus.irq & ~kernel & ~bus.exc;
  assign retire   = ~bus.exc & ~take_irq & ~bus.stall;

  pc_target_calc u_target_calc (
    .kernel_i       (kernel),
    .pc_plus4_i     (pc_plus4),
    .pc_src_i       (bus.pc_src),
    .branch_taken_i (bus.branch_taken),
    .imm16_i        (bus.imm16),
    .jump_index_i   (bus.jump_index),
    .jr_target_i    (bus.jr_target),
    .target_o       (target)
  );

  always_comb begin
    pc_d      = target;
    epc_d     = epc_q;
    irq_ack_d = 1'b0;
    exc_ack_d = 1'b0;
    if (bus.exc) begin
      pc_d      = trap_addr(EXC_VEC);
      epc_d     = pc_plus4;
      exc_ack_d = 1'b1;
    end else if (take_irq) begin
      pc_d      = trap_addr(IRQ_VEC);
      epc_d     = pc_q;
      irq_ack_d = 1'b1;
    end else if (bus.stall) begin
      pc_d      = pc_q;
    end
  end

  assign instret_d = retire ? instret_q + 32'd1 : instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      epc_q     <= 32'd0;
      instret_q <= 32'd0;
      irq_ack_q <= 1'b0;
      exc_ack_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      instret_q <= instret_d;
      irq_ack_q <= irq_ack_d;
      exc_ack_q <= exc_ack_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.kernel   = kernel;
  assign bus.epc      = epc_q;
  assign bus.irq_ack  = irq_ack_q;
  assign bus.exc_ack  = exc_ack_q;
  assign bus.instret  = instret_q;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and next-PC logic for the single-cycle MIPS core. It drives the address bus of the instruction ROM and selects the next PC from five sources: sequential, branch, jump, jump-register and the trap vectors. It also handles the kernel/user bit (PC[31]), interrupt and exception redirection, the EPC register and a retired-instruction counter.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset (kernel mode, ROM word 0)
- IRQ_VEC, 32'h8000_0004, interrupt vector (ROM word 1)
- EXC_VEC, 32'h8000_0008, exception vector (ROM word 2)

Ports:
- clk  in  1  single system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  hold PC (no advance) this cycle
- pc_src  in  2  next-PC select: SEQ=0, BRANCH=1, JUMP=2, JR=3
- branch_taken  in  1  branch condition result; qualifies BRANCH
- imm16  in  16  branch offset in words, sign-extended
- jump_index  in  26  J/JAL target field
- jr_target  in  32  register value for JR/JALR
- irq  in  1  level-sensitive external interrupt request
- exc  in  1  exception request from decoder (undefined opcode)
- pc  out  32  current PC, drives the instruction ROM address
- pc_plus4  out  32  pc + 4, combinational, for link writes
- kernel  out  1  equals pc[31]
- epc  out  32  saved return address
- irq_ack  out  1  one-cycle pulse: interrupt redirect taken last edge
- exc_ack  out  1  one-cycle pulse: exception redirect taken last edge
- instret  out  32  count of normally retired instructions

## Operation
- Next-PC priority, highest first:
  - exc: next = EXC_VEC; epc <= pc_plus4. The offending instruction is skipped. Taken in both modes.
  - irq && !kernel: next = IRQ_VEC; epc <= pc. The interrupted instruction is replayed. Overrides stall.
  - stall: next = pc.
  - pc_src.
- pc_src selection:
  - SEQ: pc_plus4.
  - BRANCH: if branch_taken, pc_plus4 + (sext(imm16) << 2); otherwise pc_plus4.
  - JUMP: {pc_plus4[31:28], jump_index, 2'b00}.
  - JR: jr_target.
- Kernel bit rules:
  - BRANCH and JUMP targets take bit 31 from the current pc[31], so carry can never toggle mode.
  - JR from kernel uses all 32 bits; this is the only way back to user mode.
  - JR from user forces bit 31 to 0.
  - Traps always set bit 31.
- Addresses are byte addresses. Bits [1:0] of all targets are forced to 0.
- irq held high while in kernel is ignored. It is taken on the first cycle after kernel drops, provided no exc is present.
- instret increments by 1 on each edge where the update is neither stall nor trap. It wraps from 2^32-1 to 0.
- epc updates only on trap edges and holds otherwise.

## Timing
- Reset values:
  - pc = RESET_PC, kernel = 1
  - epc = 0, instret = 0
  - irq_ack = 0, exc_ack = 0
- pc_plus4, kernel and the next-PC mux are combinational from pc and the inputs.
- pc, epc, instret and the acks are registered.
- Latency is 1 edge from input to new pc.
- An ack is high for exactly the cycle in which pc equals its vector after a redirect.
- Simultaneous exc and irq: exception wins. irq stays pending if still asserted.
- Asynchronous reset mid-cycle: all registers return to reset values immediately, with no pending-trap memory.
- exc together with stall: the trap wins and stall is ignored.

## Structure
- Package mips_pc_pkg holds:
  - PCSRC_SEQ, PCSRC_BRANCH, PCSRC_JUMP, PCSRC_JR
  - default vector constants RESET_PC, IRQ_VEC, EXC_VEC
  - KERNEL_BIT = 31
- One combinational sub-module, pc_target_calc: branch adder, jump concatenation, kernel-bit masking.
- The top level holds the priority mux and all registers.

## Test plan
- Reset, then 3 SEQ cycles: pc 0x80000000 → 0x80000004 → 0x80000008 → 0x8000000C; instret = 3.
- pc = 0x80000040, BRANCH taken, imm16 = 0xFFFD: next pc 0x80000038. Same case with branch_taken = 0: next pc 0x80000044.
- Kernel JR with jr_target 0x0000000C: kernel = 0, pc = 0x0C. Then user JR to 0x80000100: pc = 0x00000100.
- User mode, pc = 0x00000050, irq = 1 together with stall = 1: pc = 0x80000004, epc = 0x00000050, irq_ack pulses. irq held high afterwards is ignored while kernel = 1.
- exc and irq together at pc = 0x00000020: pc = 0x80000008, epc = 0x00000024, exc_ack = 1, irq_ack = 0.
- Assert reset asynchronously mid-cycle with instret = 0xFFFFFFFF: pc = 0x80000000 and instret = 0 immediately. Separately, 0xFFFFFFFF plus one retire wraps to 0.
